fetch_unit: RTL

- Instruction-fetch front end for the RV32I core.
- Sits directly upstream of the core's decode/execute datapath: generates sequential fetch addresses and issues them to an instruction memory over a request/response handshake.
- Buffers returned words with their PCs in a small prefetch FIFO and presents them in order to the core.
- On a core redirect (taken branch/jump), flushes the FIFO, drops in-flight responses and restarts fetch at the new PC.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch front end. Issues sequential word fetches under a
// credit limit, buffers responses with their PCs in a prefetch FIFO, and flushes on redirect.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_fifo_data [DEPTH];
  logic [31:0]   r_fifo_pc   [DEPTH];

  logic [31:0]   w_redirect_pc;
  logic [CW+1:0] w_in_use;
  logic          w_accept;
  logic          w_rsp_drop;
  logic          w_rsp_take;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_discard_redirect;
  logic          w_unused;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused      = ^redirect_pc[1:0];

  // FIFO entries, in-flight requests and still-to-be-dropped responses all share one budget.
  assign w_in_use  = (CW+2)'(r_count) + (CW+2)'(r_outstanding) + (CW+2)'(r_discard);
  assign imem_req  = !rst && !redirect && (w_in_use < (CW+2)'(DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_ready;

  // Stale responses are retired first; a response with nothing owed to it is ignored.
  assign w_rsp_drop = imem_rvalid && (r_discard != '0);
  assign w_rsp_take = imem_rvalid && (r_discard == '0) && (r_outstanding != '0);
  assign w_push     = w_rsp_take && !redirect;

  assign inst_valid = (r_count != '0);
  assign w_pop      = inst_valid && inst_ready && !redirect;
  assign inst_data  = inst_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign inst_pc    = inst_valid ? r_fifo_pc[r_rd_ptr]   : '0;

  assign w_discard_redirect = r_discard + r_outstanding
                            - CW'(w_rsp_drop) - CW'(w_rsp_take);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (redirect) begin
      r_fetch_pc    <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= w_discard_redirect;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_rsp_drop) begin
        r_discard <= r_discard - CW'(1);
      end
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_take);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; reads are gated by inst_valid instead.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

endmodule
